// File: rtl/stream_pkg.sv
// stream_pkg: shared types and helpers for the stream serializer
package stream_pkg;

    typedef enum logic {EMPTY, BUSY} ser_state_t;

    function automatic int beat_cnt_w(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/stream_serializer.sv
// stream_serializer: wide-to-narrow valid/ready converter, one WIDTH*RATIO word -> RATIO WIDTH-bit beats, LSB slice first
//   clk, rstn (sync, active-low)
//   s_valid/s_ready/s_data : wide input word stream
//   m_valid/m_ready/m_data : narrow output beat stream
//   STREAM_SERIALIZER_LAST_EN : adds s_last (captured with the word) and m_last (flags the final beat)
module stream_serializer
    import stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH*RATIO-1:0] s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data
`ifdef STREAM_SERIALIZER_LAST_EN
   ,input  logic                   s_last,
    output logic                   m_last
`endif
);
    localparam int CW = beat_cnt_w(RATIO);
    localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);

    ser_state_t                   state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [RATIO-1:0][WIDTH-1:0]  word_q, word_d;
    logic                         accept, fin;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
        word_q <= word_d;
    end

    always_comb begin
        accept  = s_valid && s_ready;
        fin     = state_q == BUSY && cnt_q == LAST_BEAT && m_ready;
        state_d = accept ? BUSY : fin ? EMPTY : state_q;
        cnt_d   = accept ? '0 : (state_q == BUSY && m_ready) ? (cnt_q == LAST_BEAT ? '0 : cnt_q + 1'b1) : cnt_q;
        word_d  = accept ? s_data : word_q;
    end

    // s_ready looks at m_ready combinationally so a new word lands in the same cycle the last beat leaves
    always_comb begin
        s_ready = rstn && (state_q == EMPTY || (cnt_q == LAST_BEAT && m_ready));
        m_valid = state_q == BUSY;
        m_data  = word_q[cnt_q];
    end

`ifdef STREAM_SERIALIZER_LAST_EN
    logic last_q;

    always_ff @(posedge clk) begin
        if (!rstn)
            last_q <= 1'b0;
        else if (accept)
            last_q <= s_last;
    end

    assign m_last = last_q && cnt_q == LAST_BEAT;
`endif

endmodule

// File: tb/tb_stream_serializer.sv
// tb_stream_serializer: directed checks of stream_serializer plus a RATIO=2 random scoreboard run
module tb_stream_serializer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [31:0] s_data;
    logic [7:0]  m_data;
    logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [31:0] b_s_data;
    logic [15:0] b_m_data;
    int          checks = 0;
    int          errors = 0;
`ifdef STREAM_SERIALIZER_LAST_EN
    logic        s_last, m_last, b_s_last, b_m_last;
`endif

    always #5 clk = ~clk;

    stream_serializer #(.WIDTH(8), .RATIO(4)) u_dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef STREAM_SERIALIZER_LAST_EN
       ,.s_last(s_last), .m_last(m_last)
`endif
    );

    stream_serializer #(.WIDTH(16), .RATIO(2)) u_dut2 (
        .clk(clk), .rstn(rstn),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data)
`ifdef STREAM_SERIALIZER_LAST_EN
       ,.s_last(b_s_last), .m_last(b_m_last)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  exp8 [8];
        logic [15:0] q [$];
        int          k, cyc, sent;
        bit          acc;

        exp8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
`ifdef STREAM_SERIALIZER_LAST_EN
        s_last = 1'b0; b_s_last = 1'b0;
`endif
        tick(); tick();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        rstn = 1'b1; #1;
        chk("rel_s_ready", s_ready, 1);

        // single word, free-flowing output
        s_valid = 1'b1; s_data = 32'h44332211; m_ready = 1'b1;
        tick(); s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_m_valid", m_valid, 1);
            chk("t1_m_data", m_data, exp8[i]);
            chk("t1_s_ready", s_ready, i == 3);
            tick();
        end
        chk("t1_drop", m_valid, 0);

        // back-to-back words, no bubble
        s_valid = 1'b1; s_data = 32'h44332211;
        tick(); s_data = 32'h88776655;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) s_valid = 1'b0;
            chk("t2_m_valid", m_valid, 1);
            chk("t2_m_data", m_data, exp8[i]);
            chk("t2_s_ready", s_ready, i == 3 || i == 7);
            tick();
        end
        chk("t2_drop", m_valid, 0);

        // same stream with m_ready alternating
        s_valid = 1'b1; s_data = 32'h44332211;
        tick(); s_data = 32'h88776655;
        k = 0; cyc = 0;
        while (k < 8 && cyc < 40) begin
            m_ready = (cyc % 2) == 0; #1;
            chk("t3_m_valid", m_valid, 1);
            chk("t3_m_data", m_data, exp8[k]);
            chk("t3_s_ready", s_ready, k % 4 == 3 && m_ready);
            acc = s_valid && (k % 4 == 3) && m_ready;
            if (m_ready) k++;
            cyc++;
            tick();
            if (acc) s_valid = 1'b0;
        end
        chk("t3_all_beats", k, 8);
        chk("t3_drop", m_valid, 0);

        // reset in the middle of a word
        m_ready = 1'b1; s_valid = 1'b1; s_data = 32'h44332211;
        tick(); s_valid = 1'b0;
        chk("t4_b0", m_data, 8'h11);
        tick();
        chk("t4_b1", m_data, 8'h22);
        tick();
        rstn = 1'b0; #1;
        chk("t4_rst_s_ready", s_ready, 0);
        tick();
        chk("t4_rst_m_valid", m_valid, 0);
        rstn = 1'b1; #1;
        chk("t4_rel_s_ready", s_ready, 1);
        s_valid = 1'b1; s_data = 32'hDDCCBBAA;
        tick(); s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_m_valid", m_valid, 1);
            chk("t4_m_data", m_data, {4'(10 + i), 4'(10 + i)});
            tick();
        end
        chk("t4_drop", m_valid, 0);

`ifdef STREAM_SERIALIZER_LAST_EN
        // last flag follows its own word
        s_valid = 1'b1; s_data = 32'h44332211; s_last = 1'b1;
        tick(); s_data = 32'h88776655; s_last = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) s_valid = 1'b0;
            chk("t5_m_data", m_data, exp8[i]);
            chk("t5_m_last", m_last, i == 3);
            tick();
        end
        chk("t5_idle_last", m_last, 0);
`endif

        // RATIO=2 WIDTH=16 random scoreboard
        sent = 0; cyc = 0;
        while ((sent < 300 || q.size() > 0 || b_m_valid) && cyc < 20000) begin
            if (!b_s_valid && sent < 300 && $urandom_range(3) != 0) begin
                b_s_valid = 1'b1;
                b_s_data = $urandom;
            end
            b_m_ready = $urandom_range(3) != 0;
            #1;
            acc = b_s_valid && b_s_ready;
            if (b_m_valid && b_m_ready) begin
                if (q.size() == 0) chk("t6_unexpected_beat", b_m_data, 'x);
                else chk("t6_beat", b_m_data, q.pop_front());
            end
            if (acc) begin
                q.push_back(b_s_data[15:0]);
                q.push_back(b_s_data[31:16]);
                sent++;
            end
            cyc++;
            tick();
            if (acc) b_s_valid = 1'b0;
        end
        chk("t6_words", sent, 300);
        chk("t6_drained", q.size(), 0);
        chk("t6_in_budget", cyc < 20000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
